fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Multi-cycle instruction-fetch controller for the Eka core.
//  - Sequences each instruction: request -> wait -> execute.
//  - Drives the imem request/ack handshake.
//  - Owns the `stall` input of the PC register, so PC advances exactly once per retired instruction.
//  - Sits between the PC block, instruction memory and decode; detects imem hangs with a watchdog.
// PARAMETERS
//  ADDR_WIDTH      32           byte-address width; pc_in is ADDR_WIDTH-2 (word address)
//  TIMEOUT_CYCLES  16           FETCH cycles without ack before ERROR; legal range 1..255
//  CNT_WIDTH       32           width of retired-instruction counter
//  NOP_INSTR       32'h00000013 value of instr after reset (addi x0,x0,0)
// PORTS
//  clk          in   1             clock, rising edge
//  reset        in   1             synchronous, active-high
//  pc_in        in   ADDR_WIDTH-2  current word PC from PC register
//  core_busy    in   1             downstream multi-cycle op (e.g. load) not finished
//  imem_ack     in   1             imem: imem_rdata valid this cycle
//  imem_rdata   in   32            imem read data
//  imem_req     out  1             imem request
//  imem_addr    out  ADDR_WIDTH    byte address = {pc_in, 2'b00}
//  instr        out  32            instruction to decode
//  instr_valid  out  1             instr is valid and executing
//  stall        out  1             hold PC register when 1
//  timeout_err  out  1             sticky imem-timeout flag
//  fetch_count  out  CNT_WIDTH     retired-instruction count
// BEHAVIOUR
//  States: IDLE, FETCH, EXEC, ERROR (registered state).
//  Reset (sync, wins over everything): state=IDLE.
//   - Outputs: imem_req=0, instr=NOP_INSTR, instr_valid=0, stall=1, timeout_err=0, fetch_count=0.
//   - Watchdog = 0.
//  IDLE:
//   - One cycle only, then FETCH unconditionally; lets the PC register leave reset.
//  FETCH:
//   - imem_req=1; imem_addr combinational from pc_in (stable, since stall=1).
//   - ack=1: latch imem_rdata into instr, go to EXEC, clear watchdog.
//   - ack=0: watchdog+1; when it reaches TIMEOUT_CYCLES-1 with no ack, go to ERROR.
//   - ack in the same cycle as the timeout threshold: ack wins.
//  EXEC:
//   - imem_req=0, instr_valid=1, instr held stable.
//   - core_busy=1: stay in EXEC, stall=1.
//   - core_busy=0: stall=0 (PC takes pc_next at this edge), fetch_count+1, go to FETCH.
//  ERROR:
//   - timeout_err=1 (sticky), imem_req=0, instr_valid=0, stall=1.
//   - Left only by reset.
//  stall = ~(state==EXEC && !core_busy); decoded combinationally from registered state.
//  imem_ack outside FETCH: ignored; no latch, no state change.
//  Latency: ack in the first FETCH cycle gives 2 cycles per instruction minimum (FETCH, EXEC).
//  fetch_count: wraps to 0 at 2^CNT_WIDTH without error.
//  Reset mid-FETCH: request dropped the next cycle; a late ack is ignored.
//   - The imem side must tolerate a withdrawn request.
//  Jump/branch redirect needs no special handling: pc_next is sampled at the EXEC exit edge.
// TESTING
//  1. Reset, imem acks in the same cycle as req, core_busy=0, PC 0->1->2:
//     - imem_addr = 0x0, 0x4, 0x8.
//     - stall low one cycle in every two.
//     - fetch_count=3 after 3 EXECs.
//  2. Ack delayed 3 cycles:
//     - imem_req high 4 cycles, stall=1 throughout.
//     - instr = rdata 0xDEADBEEF in EXEC; timeout_err stays 0.
//  3. core_busy=1 for 5 EXEC cycles:
//     - instr_valid held 6 cycles, stall=1 for the first 5.
//     - PC unchanged until core_busy=0; fetch_count increments once.
//  4. No ack, TIMEOUT_CYCLES=16:
//     - ERROR after exactly 16 FETCH cycles; timeout_err=1, imem_req=0.
//     - A later ack is ignored; only reset clears it.
//  5. Ack on the 16th FETCH cycle -> EXEC, timeout_err=0 (ack wins).
//  6. Reset asserted mid-FETCH and mid-EXEC:
//     - All outputs equal reset values the next cycle; IDLE then FETCH at imem_addr=0.
//     - fetch_count preset near 2^CNT_WIDTH-1 wraps to 0 on the next retire.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: request/wait/execute instruction-fetch controller with imem watchdog.
// Owns the PC register stall so the PC advances exactly once per retired instruction.
module fetch_sequencer #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          CNT_WIDTH      = 32,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-3:0] pc_in,
    input  logic                  core_busy,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    output logic                  stall,
    output logic                  timeout_err,
    output logic [CNT_WIDTH-1:0]  fetch_count
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERROR} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [7:0]           wd_q, wd_d;
    logic [31:0]          instr_q, instr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wd_q    <= '0;
            instr_q <= NOP_INSTR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    // An ack on the threshold cycle is checked first, so it beats the timeout.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    wd_d    = '0;
                    state_d = EXEC;
                end else if (wd_q == WD_LAST) begin
                    state_d = ERROR;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            EXEC: begin
                if (!core_busy) begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = FETCH;
                end
            end
            ERROR: ;
        endcase
    end

    assign imem_req    = state_q == FETCH;
    assign imem_addr   = {pc_in, 2'b00};
    assign instr       = instr_q;
    assign instr_valid = state_q == EXEC;
    assign stall       = ~(state_q == EXEC && !core_busy);
    assign timeout_err = state_q == ERROR;
    assign fetch_count = cnt_q;
endmodule
